// File: rtl/kamikaze_prefetch_buffer.sv
// Instruction prefetch buffer: word fetch queue with halfword realignment
// for mixed 16/32-bit instruction streams.
module kamikaze_prefetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_data_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);

  logic [31:0]   q_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  logic          inflight;
  logic          offset;
  logic [31:0]   fetch_ptr;
  logic [31:0]   pc;

  logic [31:0] head;
  logic [31:0] nxt;
  logic [15:0] low_hw;
  logic        is_c;
  logic        have1;
  logic        have2;
  logic        valid;
  logic [31:0] raw;
  logic        consume;
  logic        pop;
  logic        push;
  logic        overflow;
  logic        unused_pc_bit;

  assign unused_pc_bit = redirect_pc_i[0];

  assign rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  assign wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

  assign head   = q_mem[rd_ptr];
  assign nxt    = q_mem[rd_nxt];
  assign low_hw = offset ? head[31:16] : head[15:0];
  assign is_c   = (low_hw[1:0] != 2'b11);
  assign have1  = (count != '0);
  assign have2  = (count >= TWO);

  always_comb begin
    valid = 1'b0;
    raw   = '0;
    unique case (1'b1)
      is_c: begin
        valid = have1;
        raw   = {16'h0000, low_hw};
      end
      (!is_c && !offset): begin
        valid = have1;
        raw   = head;
      end
      (!is_c && offset): begin
        valid = have2;
        raw   = {nxt[15:0], head[31:16]};
      end
    endcase
  end

  assign consume = valid & instr_ready_i & ~redirect_i;
  // A word leaves the queue whenever the consumed halfwords run past its top.
  assign pop     = consume & (offset | ~is_c);
  assign push    = inflight & ~redirect_i;

  assign demand   = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
  assign im_req_o = rst_i & ~redirect_i & (demand < LIM);
  assign overflow = push & ~pop & (count == FULL);

  assign im_addr_o             = fetch_ptr;
  assign pc_o                  = pc;
  assign instr_valid_o         = valid;
  assign instr_o               = valid ? raw : '0;
  assign is_compressed_instr_o = valid & is_c;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_ptr <= {RESET_PC[31:2], 2'b00};
      pc        <= RESET_PC;
      offset    <= RESET_PC[1];
      inflight  <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else begin
      inflight <= im_req_o;
      if (redirect_i) begin
        fetch_ptr <= {redirect_pc_i[31:2], 2'b00};
        pc        <= {redirect_pc_i[31:1], 1'b0};
        offset    <= redirect_pc_i[1];
        count     <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (im_req_o) begin
          fetch_ptr <= fetch_ptr + 32'd4;
        end
        if (push) begin
          q_mem[wr_ptr] <= im_data_i;
          wr_ptr        <= wr_nxt;
        end
        if (pop) begin
          rd_ptr <= rd_nxt;
        end
        count <= count + CW'(push) - CW'(pop);
        if (consume) begin
          pc     <= pc + (is_c ? 32'd2 : 32'd4);
          offset <= offset ^ is_c;
        end
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_i) !overflow
  ) else $error("prefetch queue overflow");

endmodule
